// File: rtl/clk_gen_multi.sv
// rtl/clk_gen_multi.sv - multi-channel programmable clock generator
// Each channel runs an IDLE/PHASE/HIGH/LOW FSM off shadowed high/low/phase counts.
module clk_gen_multi #(
  parameter int CH = 4,
  parameter int CNT_W = 8,
  localparam int CW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             cfg_wr,
  input  logic [CW-1:0]    cfg_ch,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_low,
  input  logic [CNT_W-1:0] cfg_phase,
  output logic [CH-1:0]    clk_out,
  output logic [CH-1:0]    rise_pulse,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, PHASE, HIGH, LOW} state_t;

  state_t           state_q  [CH];
  state_t           state_d  [CH];
  logic [CNT_W-1:0] cnt_q    [CH];
  logic [CNT_W-1:0] cnt_d    [CH];
  logic             stop_q   [CH];
  logic             stop_d   [CH];
  logic             reload   [CH];
  logic [CNT_W-1:0] sh_high  [CH];
  logic [CNT_W-1:0] sh_low   [CH];
  logic [CNT_W-1:0] sh_phase [CH];
  logic [CNT_W-1:0] act_high [CH];
  logic [CNT_W-1:0] act_low  [CH];
  logic             run_q;
  logic             armed_q;
  logic             start;

  // Counts of 0 behave as 1; the counter holds remaining cycles minus one.
  function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_W'(1);
  endfunction

  // armed_q blocks a start until run has been seen low after reset.
  assign start = run & ~run_q & armed_q;

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      stop_d[i]  = stop_q[i];
      reload[i]  = 1'b0;
      case (state_q[i])
        IDLE: begin
          stop_d[i] = 1'b0;
          if (start) begin
            reload[i] = 1'b1;
            if (sh_phase[i] == '0) begin
              state_d[i] = HIGH;
              cnt_d[i]   = len_m1(sh_high[i]);
            end else begin
              state_d[i] = PHASE;
              cnt_d[i]   = sh_phase[i] - CNT_W'(1);
            end
          end
        end
        PHASE: begin
          if (!run) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == '0) begin
            state_d[i] = HIGH;
            cnt_d[i]   = len_m1(act_high[i]);
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
          end
        end
        HIGH: begin
          // A stop seen anywhere in HIGH is remembered so a quick re-raise of run cannot extend it.
          if (!run) stop_d[i] = 1'b1;
          if (cnt_q[i] == '0) begin
            if (!run || stop_q[i]) begin
              state_d[i] = IDLE;
              cnt_d[i]   = '0;
              stop_d[i]  = 1'b0;
            end else begin
              state_d[i] = LOW;
              cnt_d[i]   = len_m1(act_low[i]);
            end
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
          end
        end
        LOW: begin
          if (!run) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == '0) begin
            reload[i]  = 1'b1;
            state_d[i] = HIGH;
            cnt_d[i]   = len_m1(sh_high[i]);
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      armed_q    <= 1'b0;
      clk_out    <= '0;
      rise_pulse <= '0;
      for (int i = 0; i < CH; i++) begin
        state_q[i]  <= IDLE;
        cnt_q[i]    <= '0;
        stop_q[i]   <= 1'b0;
        sh_high[i]  <= CNT_W'(1);
        sh_low[i]   <= CNT_W'(1);
        sh_phase[i] <= '0;
        act_high[i] <= CNT_W'(1);
        act_low[i]  <= CNT_W'(1);
      end
    end else begin
      run_q   <= run;
      armed_q <= armed_q | ~run;
      for (int i = 0; i < CH; i++) begin
        state_q[i]    <= state_d[i];
        cnt_q[i]      <= cnt_d[i];
        stop_q[i]     <= stop_d[i];
        clk_out[i]    <= (state_d[i] == HIGH);
        rise_pulse[i] <= (state_d[i] == HIGH) && (state_q[i] != HIGH);
        // Reload samples the pre-write shadow, so a same-edge write lands one period later.
        if (reload[i]) begin
          act_high[i] <= sh_high[i];
          act_low[i]  <= sh_low[i];
        end
        if (cfg_wr && cfg_ch == CW'(i)) begin
          sh_high[i]  <= cfg_high;
          sh_low[i]   <= cfg_low;
          sh_phase[i] <= cfg_phase;
        end
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < CH; i++) busy = busy | (state_q[i] != IDLE);
  end

endmodule

// File: tb/tb_clk_gen_multi.sv
// tb/tb_clk_gen_multi.sv - directed self-checking bench for clk_gen_multi
module tb_clk_gen_multi;
  localparam int CH = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       run = 1'b0;
  logic       cfg_wr = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_high = '0;
  logic [7:0] cfg_low = '0;
  logic [7:0] cfg_phase = '0;
  logic [2:0] clk_out;
  logic [2:0] rise_pulse;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  clk_gen_multi #(.CH(CH), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
    .cfg_high(cfg_high), .cfg_low(cfg_low), .cfg_phase(cfg_phase),
    .clk_out(clk_out), .rise_pulse(rise_pulse), .busy(busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int ch, input int h, input int l, input int p);
    cfg_wr = 1'b1; cfg_ch = 2'(ch);
    cfg_high = 8'(h); cfg_low = 8'(l); cfg_phase = 8'(p);
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic settle;
    run = 1'b0;
    for (int i = 0; i < 600 && busy; i++) tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL settle_busy got %b want 0", busy);
    end
    tick();
  endtask

  task automatic test_reset;
    #3 rst_n = 1'b0;
    run = 1'b1;
    #9;
    n_cmp++;
    if ({clk_out, rise_pulse, busy} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_outputs got %b want 0000000", {clk_out, rise_pulse, busy});
    end
    rst_n = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if ({clk_out, busy} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_run_high_no_start got %b want 0000", {clk_out, busy});
    end
    run = 1'b0; tick();
    run = 1'b1; tick();
    for (int c = 0; c < 7; c++) begin
      logic [2:0] e;
      e = (c % 2 == 0) ? 3'b111 : 3'b000;
      n_cmp++;
      if ({clk_out, rise_pulse} !== {e, e}) begin
        n_bad++;
        $display("FAIL default_period2 c=%0d got %b want %b", c, {clk_out, rise_pulse}, {e, e});
      end
      tick();
    end
    settle();
  endtask

  task automatic test_program;
    logic [23:0] o0, o1, r0, r1, e0, e1, er0, er1;
    cfg(0, 3, 5, 0);
    cfg(1, 2, 2, 4);
    cfg(2, 1, 1, 0);
    run = 1'b1; tick();
    for (int c = 0; c < 24; c++) begin
      o0[c] = clk_out[0]; o1[c] = clk_out[1];
      r0[c] = rise_pulse[0]; r1[c] = rise_pulse[1];
      e0[c]  = (c % 8) < 3;
      er0[c] = (c % 8) == 0;
      e1[c]  = (c >= 4) && (((c - 4) % 4) < 2);
      er1[c] = (c >= 4) && (((c - 4) % 4) == 0);
      tick();
    end
    n_cmp++;
    if (o0 !== e0) begin n_bad++; $display("FAIL prog_ch0_clk got %b want %b", o0, e0); end
    n_cmp++;
    if (r0 !== er0) begin n_bad++; $display("FAIL prog_ch0_rise got %b want %b", r0, er0); end
    n_cmp++;
    if (o1 !== e1) begin n_bad++; $display("FAIL prog_ch1_clk got %b want %b", o1, e1); end
    n_cmp++;
    if (r1 !== er1) begin n_bad++; $display("FAIL prog_ch1_rise got %b want %b", r1, er1); end
    settle();
  endtask

  task automatic test_stop_mid_high;
    logic [5:0] oc, ob;
    cfg(0, 6, 2, 0);
    cfg(1, 1, 1, 0);
    run = 1'b1; tick();
    tick();
    n_cmp++;
    if (clk_out[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL stop_pre_high got %b want 1", clk_out[0]);
    end
    run = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      oc[c] = clk_out[0];
      ob[c] = busy;
    end
    n_cmp++;
    if (oc !== 6'b001111) begin n_bad++; $display("FAIL stop_clk got %b want 001111", oc); end
    n_cmp++;
    if (ob !== 6'b001111) begin n_bad++; $display("FAIL stop_busy got %b want 001111", ob); end
    settle();
  endtask

  task automatic test_reconfig;
    string exp_s;
    logic [23:0] obs, e;
    exp_s = "110011110111101100011000";
    cfg(0, 2, 2, 0);
    run = 1'b1; tick();
    for (int c = 0; c < 24; c++) begin
      obs[c] = clk_out[0];
      e[c] = (exp_s[c] == "1");
      cfg_wr = 1'b0;
      if (c == 0) begin
        cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_high = 8'd4; cfg_low = 8'd1; cfg_phase = 8'd0;
      end else if (c == 8) begin
        cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_high = 8'd2; cfg_low = 8'd3; cfg_phase = 8'd0;
      end
      tick();
    end
    cfg_wr = 1'b0;
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL reconfig_trace got %b want %b", obs, e); end
    settle();
  endtask

  task automatic test_boundaries;
    int err0, err1, err2;
    logic r510;
    err0 = 0; err1 = 0; err2 = 0; r510 = 1'b0;
    cfg(0, 0, 0, 0);
    cfg(1, 255, 255, 0);
    cfg(2, 1, 1, 0);
    cfg(3, 7, 7, 7);
    run = 1'b1; tick();
    for (int c = 0; c < 520; c++) begin
      if (clk_out[0] !== ((c % 2) == 0)) err0++;
      if (clk_out[1] !== ((c % 510) < 255)) err1++;
      if (clk_out[2] !== ((c % 2) == 0)) err2++;
      if (c == 510) r510 = rise_pulse[1];
      tick();
    end
    n_cmp++;
    if (err0 != 0) begin n_bad++; $display("FAIL bound_zero_hl errors got %0d want 0", err0); end
    n_cmp++;
    if (err1 != 0) begin n_bad++; $display("FAIL bound_max_hl errors got %0d want 0", err1); end
    n_cmp++;
    if (r510 !== 1'b1) begin n_bad++; $display("FAIL bound_max_rise got %b want 1", r510); end
    n_cmp++;
    if (err2 != 0) begin n_bad++; $display("FAIL bound_bad_ch errors got %0d want 0", err2); end
    settle();
  endtask

  task automatic test_async_reset;
    cfg(0, 5, 5, 3);
    run = 1'b1; tick();
    repeat (3) tick();
    n_cmp++;
    if ({clk_out[0], busy} !== 2'b11) begin
      n_bad++;
      $display("FAIL async_pre got %b want 11", {clk_out[0], busy});
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({clk_out, rise_pulse, busy} !== 7'b0) begin
      n_bad++;
      $display("FAIL async_clear got %b want 0000000", {clk_out, rise_pulse, busy});
    end
    #1 rst_n = 1'b1;
    repeat (2) tick();
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL async_rearm busy got %b want 0", busy); end
    run = 1'b0; tick();
    run = 1'b1; tick();
    for (int c = 0; c < 3; c++) begin
      logic [2:0] e;
      e = (c % 2 == 0) ? 3'b111 : 3'b000;
      n_cmp++;
      if (clk_out !== e) begin
        n_bad++;
        $display("FAIL async_defaults c=%0d got %b want %b", c, clk_out, e);
      end
      tick();
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_program();
    test_stop_mid_high();
    test_reconfig();
    test_boundaries();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
